// File: rtl/alu_uart_ctrl.sv
// alu_uart_ctrl: collects operand A, operand B and an opcode byte from the
// UART receiver, presents them to the ALU, and hands the ALU result to the
// UART transmitter with a start/done handshake.
// Optional inter-byte timeout is compiled in with `define ALU_CTRL_TIMEOUT_EN.
//
// state   | meaning
// --------+---------------------------------------------------------------
// WAIT_A  | idle, next received byte is operand A
// WAIT_B  | next received byte is operand B
// WAIT_OP | next received byte is the opcode, checked before use
// EXEC    | ALU settles on the registered operands; result captured
// SEND    | tx_start high for this one cycle
// WAIT_TX | waiting for the transmitter to finish the byte
module alu_uart_ctrl #(
   parameter int NB_DATA        = 8,
   parameter int NB_OPCODE      = 6,
   parameter int TIMEOUT_CYCLES = 100000
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 rx_done,
   input  logic [NB_DATA-1:0]   rx_data,
   input  logic                 tx_done,
   input  logic [NB_DATA-1:0]   alu_result,
   output logic [NB_DATA-1:0]   alu_a,
   output logic [NB_DATA-1:0]   alu_b,
   output logic [NB_OPCODE-1:0] alu_op,
   output logic                 tx_start,
   output logic [NB_DATA-1:0]   tx_data,
   output logic                 busy,
   output logic                 op_err,
   output logic                 timeout
);

   typedef enum logic [2:0] {
      WAIT_A  = 3'd0,
      WAIT_B  = 3'd1,
      WAIT_OP = 3'd2,
      EXEC    = 3'd3,
      SEND    = 3'd4,
      WAIT_TX = 3'd5
   } state_t;

   localparam logic [NB_OPCODE-1:0] OP_ADD = NB_OPCODE'(6'b100000);
   localparam logic [NB_OPCODE-1:0] OP_SUB = NB_OPCODE'(6'b100010);
   localparam logic [NB_OPCODE-1:0] OP_AND = NB_OPCODE'(6'b100100);
   localparam logic [NB_OPCODE-1:0] OP_OR  = NB_OPCODE'(6'b100101);
   localparam logic [NB_OPCODE-1:0] OP_XOR = NB_OPCODE'(6'b100110);
   localparam logic [NB_OPCODE-1:0] OP_NOR = NB_OPCODE'(6'b100111);
   localparam logic [NB_OPCODE-1:0] OP_SRL = NB_OPCODE'(6'b000010);
   localparam logic [NB_OPCODE-1:0] OP_SRA = NB_OPCODE'(6'b000011);

   state_t               state_q, state_d;
   logic [NB_DATA-1:0]   alu_a_q, alu_a_d;
   logic [NB_DATA-1:0]   alu_b_q, alu_b_d;
   logic [NB_OPCODE-1:0] alu_op_q, alu_op_d;
   logic [NB_DATA-1:0]   tx_data_q, tx_data_d;
   logic                 tx_start_q, tx_start_d;
   logic                 busy_q, busy_d;
   logic                 op_err_q, op_err_d;
   logic                 op_ok;
   logic                 expired;

   // Opcode byte is legal only with clear upper bits and a supported code.
   always_comb begin
      op_ok = 1'b0;
      if ((rx_data >> NB_OPCODE) == '0) begin
         case (rx_data[NB_OPCODE-1:0])
            OP_ADD, OP_SUB, OP_AND, OP_OR,
            OP_XOR, OP_NOR, OP_SRL, OP_SRA: op_ok = 1'b1;
            default:                        op_ok = 1'b0;
         endcase
      end
   end

`ifdef ALU_CTRL_TIMEOUT_EN
   localparam int             CW      = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CW-1:0]  TO_LAST = CW'(TIMEOUT_CYCLES);

   logic [CW-1:0] tcnt_q, tcnt_d;
   logic          timeout_q, timeout_d;

   // A byte arriving in the expiry cycle takes priority over the timeout.
   assign expired = ((state_q == WAIT_B) || (state_q == WAIT_OP)) &&
                    !rx_done && (tcnt_q == TO_LAST);

   // Inter-byte counter runs only while waiting mid-sequence; any accepted
   // byte or return to WAIT_A restarts it from zero.
   always_comb begin
      tcnt_d    = '0;
      timeout_d = expired;
      if (((state_q == WAIT_B) || (state_q == WAIT_OP)) && !rx_done && !expired) begin
         tcnt_d = tcnt_q + CW'(1);
      end
   end

   // Timeout counter and pulse registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         tcnt_q    <= '0;
         timeout_q <= 1'b0;
      end else begin
         tcnt_q    <= tcnt_d;
         timeout_q <= timeout_d;
      end
   end

   assign timeout = timeout_q;
`else
   logic [31:0] unused_timeout_cfg;
   assign unused_timeout_cfg = 32'(TIMEOUT_CYCLES);
   assign expired            = 1'b0;
   assign timeout            = 1'b0;
`endif

   // Next-state and register-update logic for the byte sequencer.
   always_comb begin
      state_d    = state_q;
      alu_a_d    = alu_a_q;
      alu_b_d    = alu_b_q;
      alu_op_d   = alu_op_q;
      tx_data_d  = tx_data_q;
      tx_start_d = 1'b0;
      op_err_d   = 1'b0;
      case (state_q)
         WAIT_A: begin
            if (rx_done) begin
               alu_a_d = rx_data;
               state_d = WAIT_B;
            end
         end
         WAIT_B: begin
            if (rx_done) begin
               alu_b_d = rx_data;
               state_d = WAIT_OP;
            end else if (expired) begin
               state_d = WAIT_A;
            end
         end
         WAIT_OP: begin
            if (rx_done) begin
               if (op_ok) begin
                  alu_op_d = rx_data[NB_OPCODE-1:0];
                  state_d  = EXEC;
               end else begin
                  op_err_d = 1'b1;
                  state_d  = WAIT_A;
               end
            end else if (expired) begin
               state_d = WAIT_A;
            end
         end
         EXEC: begin
            tx_data_d  = alu_result;
            tx_start_d = 1'b1;
            state_d    = SEND;
         end
         SEND: begin
            // A fast transmitter may finish while tx_start is still high.
            state_d = tx_done ? WAIT_A : WAIT_TX;
         end
         WAIT_TX: begin
            if (tx_done) begin
               state_d = WAIT_A;
            end
         end
         default: state_d = WAIT_A;
      endcase
      busy_d = (state_d == EXEC) || (state_d == SEND) || (state_d == WAIT_TX);
   end

   // Sequencer state and output registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= WAIT_A;
         alu_a_q    <= '0;
         alu_b_q    <= '0;
         alu_op_q   <= '0;
         tx_data_q  <= '0;
         tx_start_q <= 1'b0;
         busy_q     <= 1'b0;
         op_err_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         alu_a_q    <= alu_a_d;
         alu_b_q    <= alu_b_d;
         alu_op_q   <= alu_op_d;
         tx_data_q  <= tx_data_d;
         tx_start_q <= tx_start_d;
         busy_q     <= busy_d;
         op_err_q   <= op_err_d;
      end
   end

   assign alu_a    = alu_a_q;
   assign alu_b    = alu_b_q;
   assign alu_op   = alu_op_q;
   assign tx_data  = tx_data_q;
   assign tx_start = tx_start_q;
   assign busy     = busy_q;
   assign op_err   = op_err_q;

endmodule

// File: tb/tb_alu_uart_ctrl.sv
// Bench for alu_uart_ctrl: vector table, randomized triples against a
// behavioural model, and hand-written reset/handshake/timeout sequences.
module tb_alu_uart_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic       rx_done;
   logic [7:0] rx_data;
   logic       tx_done;
   logic [7:0] alu_result;
   logic [7:0] alu_a, alu_b, tx_data;
   logic [5:0] alu_op;
   logic       tx_start, busy, op_err, timeout;

   int n_checks = 0;
   int n_fail   = 0;
   logic [5:0] model_op;

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic [7:0] op;
      logic       vld;
      logic [7:0] res;
   } vec_t;

   vec_t vecs[12];
   logic [7:0] valid_ops[8];

   alu_uart_ctrl #(.NB_DATA(8), .NB_OPCODE(6), .TIMEOUT_CYCLES(16)) dut (
      .clk(clk), .reset(reset), .rx_done(rx_done), .rx_data(rx_data),
      .tx_done(tx_done), .alu_result(alu_result), .alu_a(alu_a), .alu_b(alu_b),
      .alu_op(alu_op), .tx_start(tx_start), .tx_data(tx_data), .busy(busy),
      .op_err(op_err), .timeout(timeout)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] alu_ref(input logic [7:0] a, input logic [7:0] b,
                                          input logic [5:0] op);
      logic [7:0] r;
      case (op)
         6'h20:   r = a + b;
         6'h22:   r = a - b;
         6'h24:   r = a & b;
         6'h25:   r = a | b;
         6'h26:   r = a ^ b;
         6'h27:   r = ~(a | b);
         6'h02:   r = a >> b;
         6'h03:   r = $signed(a) >>> b;
         default: r = 8'h00;
      endcase
      return r;
   endfunction

   function automatic logic byte_valid(input logic [7:0] v);
      foreach (valid_ops[i]) if (v == valid_ops[i]) return 1'b1;
      return 1'b0;
   endfunction

   // ALU stand-in driven from the DUT's registered operands.
   always_comb alu_result = alu_ref(alu_a, alu_b, alu_op);

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] v);
      rx_data = v;
      rx_done = 1'b1;
      step();
      rx_done = 1'b0;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_alu_a"}, alu_a, 0);
      check({tag, "_alu_b"}, alu_b, 0);
      check({tag, "_alu_op"}, alu_op, 0);
      check({tag, "_tx_data"}, tx_data, 0);
      check({tag, "_tx_start"}, tx_start, 0);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_op_err"}, op_err, 0);
      check({tag, "_timeout"}, timeout, 0);
   endtask

   task automatic finish_op(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op,
                            input logic vld, input logic [7:0] res,
                            input int txd, input logic drop);
      send_byte(op);
      if (vld) begin
         check("exec_busy", busy, 1);
         check("exec_tx_start", tx_start, 0);
         check("exec_op_err", op_err, 0);
         check("alu_a", alu_a, a);
         check("alu_b", alu_b, b);
         check("alu_op", alu_op, op[5:0]);
         model_op = op[5:0];
         step();
         check("send_tx_start", tx_start, 1);
         check("send_tx_data", tx_data, res);
         step();
         check("wait_tx_start_low", tx_start, 0);
         check("wait_tx_busy", busy, 1);
         for (int i = 0; i < txd; i++) begin
            if (drop && i < 2) begin
               rx_data = (i == 0) ? 8'hAA : 8'hBB;
               rx_done = 1'b1;
            end
            step();
            rx_done = 1'b0;
            check("wait_tx_no_start", tx_start, 0);
            check("wait_tx_data_stable", tx_data, res);
            check("wait_tx_busy_hold", busy, 1);
         end
         tx_done = 1'b1;
         step();
         tx_done = 1'b0;
         check("done_busy_low", busy, 0);
         check("done_tx_data_hold", tx_data, res);
         check("done_alu_a_hold", alu_a, a);
         check("done_alu_b_hold", alu_b, b);
      end else begin
         check("bad_op_err", op_err, 1);
         check("bad_busy", busy, 0);
         check("bad_alu_op_kept", alu_op, model_op);
         check("bad_alu_a", alu_a, a);
         step();
         check("bad_op_err_1cyc", op_err, 0);
         check("bad_no_tx_start", tx_start, 0);
         step();
         check("bad_no_tx_start2", tx_start, 0);
      end
   endtask

   task automatic run_triple(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op,
                             input logic vld, input logic [7:0] res,
                             input int gap, input int txd, input logic drop);
      send_byte(a);
      repeat (gap) step();
      send_byte(b);
      check("rx_alu_a", alu_a, a);
      repeat (gap) step();
      finish_op(a, b, op, vld, res, txd, drop);
   endtask

   initial begin
      logic [7:0] ra, rb, rop;
      valid_ops = '{8'h20, 8'h22, 8'h24, 8'h25, 8'h26, 8'h27, 8'h02, 8'h03};
      vecs[0]  = '{8'h05, 8'h03, 8'h20, 1'b1, 8'h08};
      vecs[1]  = '{8'h03, 8'h05, 8'h22, 1'b1, 8'hFE};
      vecs[2]  = '{8'h80, 8'h02, 8'h02, 1'b1, 8'h20};
      vecs[3]  = '{8'h01, 8'h02, 8'h3F, 1'b0, 8'h00};
      vecs[4]  = '{8'h01, 8'h02, 8'h60, 1'b0, 8'h00};
      vecs[5]  = '{8'h0F, 8'hF0, 8'h25, 1'b1, 8'hFF};
      vecs[6]  = '{8'h01, 8'h01, 8'h20, 1'b1, 8'h02};
      vecs[7]  = '{8'hF0, 8'h3C, 8'h24, 1'b1, 8'h30};
      vecs[8]  = '{8'hF0, 8'h3C, 8'h26, 1'b1, 8'hCC};
      vecs[9]  = '{8'hF0, 8'h0F, 8'h27, 1'b1, 8'h00};
      vecs[10] = '{8'h80, 8'h02, 8'h03, 1'b1, 8'hE0};
      vecs[11] = '{8'h12, 8'h34, 8'hA0, 1'b0, 8'h00};

      reset = 1'b1; rx_done = 1'b0; rx_data = 8'h00; tx_done = 1'b0;
      model_op = 6'h00;
      repeat (3) step();
      check_all_zero("reset");
      reset = 1'b0;
      step();

      // Directed table; entry 6 also injects dropped bytes during WAIT_TX.
      for (int i = 0; i < 12; i++)
         run_triple(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].vld, vecs[i].res,
                    i % 3, 2 + (i % 3), (i == 6));

      // rx in EXEC dropped; tx_done during SEND ends the transaction.
      send_byte(8'h04);
      send_byte(8'h04);
      rx_data = 8'h77; rx_done = 1'b1;
      send_byte(8'h20);
      check("exec_seen_busy", busy, 1);
      rx_data = 8'h77; rx_done = 1'b1;
      step();
      rx_done = 1'b0;
      check("exec_drop_start", tx_start, 1);
      check("exec_drop_alu_a", alu_a, 8'h04);
      check("exec_drop_data", tx_data, 8'h08);
      tx_done = 1'b1;
      step();
      tx_done = 1'b0;
      check("send_done_busy", busy, 0);
      check("send_done_start", tx_start, 0);
      model_op = 6'h20;
      tx_done = 1'b1;
      step();
      tx_done = 1'b0;
      check("idle_tx_done_ignored", busy, 0);
      run_triple(8'h01, 8'h01, 8'h20, 1'b1, 8'h02, 0, 1, 1'b0);

      // Reset in WAIT_OP.
      send_byte(8'h11);
      send_byte(8'h22);
      reset = 1'b1;
      step();
      reset = 1'b0;
      check_all_zero("rst_wait_op");
      model_op = 6'h00;
      step();
      check("rst_wait_op_nostart", tx_start, 0);

      // Reset in WAIT_TX.
      send_byte(8'h09);
      send_byte(8'h02);
      send_byte(8'h22);
      step();
      step();
      check("pre_rst_busy", busy, 1);
      reset = 1'b1;
      step();
      reset = 1'b0;
      check_all_zero("rst_wait_tx");
      step();
      check("rst_wait_tx_nostart", tx_start, 0);
      run_triple(8'h05, 8'h03, 8'h20, 1'b1, 8'h08, 0, 2, 1'b0);

`ifdef ALU_CTRL_TIMEOUT_EN
      // Silence after operand A: pulse one cycle after the counter reaches 16.
      send_byte(8'h05);
      for (int i = 1; i <= 16; i++) begin
         step();
         check("to_not_yet", timeout, 0);
      end
      step();
      check("to_pulse", timeout, 1);
      check("to_alu_a_kept", alu_a, 8'h05);
      step();
      check("to_pulse_1cyc", timeout, 0);
      run_triple(8'h05, 8'h03, 8'h20, 1'b1, 8'h08, 0, 1, 1'b0);
      // Byte arriving in the expiry cycle is accepted instead.
      send_byte(8'h07);
      repeat (16) step();
      send_byte(8'h02);
      check("to_race_no_pulse", timeout, 0);
      check("to_race_alu_b", alu_b, 8'h02);
      step();
      check("to_race_no_pulse2", timeout, 0);
      finish_op(8'h07, 8'h02, 8'h20, 1'b1, 8'h09, 1, 1'b0);
`else
      // Without the timeout feature a long gap never aborts the sequence.
      send_byte(8'h05);
      for (int i = 0; i < 40; i++) begin
         step();
         if (i % 10 == 0) check("no_to_timeout", timeout, 0);
      end
      send_byte(8'h03);
      repeat (40) step();
      check("no_to_timeout_b", timeout, 0);
      finish_op(8'h05, 8'h03, 8'h20, 1'b1, 8'h08, 1, 1'b0);
`endif

      // Randomized triples against the behavioural model.
      for (int k = 0; k < 40; k++) begin
         ra = 8'($urandom_range(255));
         rb = 8'($urandom_range(255));
         if ($urandom_range(3) != 0) rop = valid_ops[$urandom_range(7)];
         else rop = 8'($urandom_range(255));
         run_triple(ra, rb, rop, byte_valid(rop), alu_ref(ra, rb, rop[5:0]),
                    $urandom_range(2), $urandom_range(1, 5), 1'($urandom_range(1)));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/alu_uart_ctrl.md
# alu_uart_ctrl

Byte-serial sequencer that feeds the 8-bit ALU from a UART receiver and returns its result through a UART transmitter. It collects three received bytes (operand A, operand B, opcode), holds them on the ALU inputs, checks the opcode, captures the ALU result, and performs a start/done handshake with the transmitter. It sits between the UART rx/tx blocks and the ALU in the top level.

## Interface
- `NB_DATA`, 8: UART byte width and ALU operand/result width.
- `NB_OPCODE`, 6: ALU opcode width. Must be ≤ `NB_DATA`.
- `TIMEOUT_CYCLES`, 100000: inter-byte timeout. Used only with `ALU_CTRL_TIMEOUT_EN`.
- `clk` in 1: single clock. All logic is rising-edge.
- `reset` in 1: synchronous, active-high reset.
- `rx_done` in 1: one-cycle strobe; `rx_data` is valid in that cycle.
- `rx_data` in NB_DATA: received byte.
- `tx_done` in 1: one-cycle strobe; the transmitter has finished the byte.
- `alu_result` in NB_DATA: combinational ALU output.
- `alu_a` out NB_DATA: registered operand A to the ALU.
- `alu_b` out NB_DATA: registered operand B to the ALU.
- `alu_op` out NB_OPCODE: registered opcode to the ALU.
- `tx_start` out 1: registered one-cycle strobe requesting transmission.
- `tx_data` out NB_DATA: registered byte to transmit. Stable from `tx_start` until `tx_done`.
- `busy` out 1: high in EXEC, SEND and WAIT_TX.
- `op_err` out 1: one-cycle pulse when an opcode byte is rejected.
- `timeout` out 1: one-cycle pulse on inter-byte timeout. Tied 0 without the macro.

## Operation
- **States:** WAIT_A, WAIT_B, WAIT_OP, EXEC, SEND, WAIT_TX.
- **Reset:**
  - State goes to WAIT_A.
  - `alu_a`, `alu_b`, `alu_op`, `tx_data` reset to 0.
  - `tx_start`, `busy`, `op_err`, `timeout` reset to 0.
  - The timeout counter resets to 0.
  - Reset in any state aborts the sequence immediately, including a pending transmission.
- **WAIT_A:** on `rx_done`, `alu_a` ← `rx_data`, then go to WAIT_B.
- **WAIT_B:** on `rx_done`, `alu_b` ← `rx_data`, then go to WAIT_OP.
- **WAIT_OP:** on `rx_done`, the byte is checked.
  - Valid means bits [NB_DATA-1:NB_OPCODE] are 0 and the low bits are one of: ADD 100000, SUB 100010, AND 100100, OR 100101, XOR 100110, NOR 100111, SRL 000010, SRA 000011.
  - Valid: `alu_op` ← low NB_OPCODE bits, then go to EXEC.
  - Invalid: `alu_op` is unchanged, `op_err` pulses in the next cycle, then go to WAIT_A. No transmission.
- **EXEC:** one cycle for the ALU to settle. `tx_data` ← `alu_result`, `tx_start` ← 1, then go to SEND.
- **SEND:** `tx_start` is high for this one cycle only, then go to WAIT_TX. A `tx_done` seen in SEND counts as in WAIT_TX.
- **WAIT_TX:** on `tx_done`, go to WAIT_A.
- `rx_done` in EXEC, SEND or WAIT_TX is ignored; the byte is dropped.
- `alu_a`, `alu_b` and `alu_op` hold their values until overwritten by the next accepted byte. The ALU output therefore stays stable after transmission.
- `tx_done` outside SEND/WAIT_TX is ignored.

## Timing
- An accepted `rx_done` at edge n updates the register and the state at edge n+1.
- From the opcode `rx_done` at cycle n:
  - EXEC at n+1.
  - `tx_start` high and `tx_data` valid at n+2.
  - WAIT_TX at n+3.
- Minimum full transaction is 3 received bytes, then 3 cycles, then the `tx_done` wait.
- `tx_start` is never high for two consecutive cycles.
- `busy` is asserted in the cycle after opcode acceptance and deasserted in the cycle after `tx_done`.
- `op_err` and `timeout` are high for exactly one cycle.

## Configuration
- Macro: `ALU_CTRL_TIMEOUT_EN`.
- **Defined:**
  - A counter of width `$clog2(TIMEOUT_CYCLES+1)` clears on every accepted byte and on entry to WAIT_A.
  - It increments in WAIT_B and WAIT_OP.
  - When it reaches `TIMEOUT_CYCLES` with no `rx_done` in that cycle, the state returns to WAIT_A and `timeout` pulses. `alu_a`/`alu_b` keep their values.
  - `rx_done` in the same cycle as expiry wins: the byte is accepted and there is no timeout.
- **Undefined:** no counter; WAIT_B and WAIT_OP wait indefinitely; `timeout` is constant 0.

## Test plan
- **Add:** rx 0x05, 0x03, 0x20.
  - `tx_start` pulses 2 cycles after the opcode strobe.
  - `tx_data`=0x08 with `alu_result`=0x08; `busy` high until `tx_done`, then WAIT_A.
- **Sub and shift:** rx 0x03, 0x05, 0x22 → `tx_data`=0xFE. Then rx 0x80, 0x02, 0x02 → 0x20.
- **Bad opcode:** rx 0x01, 0x02, 0x3F, then a second run 0x01, 0x02, 0x60.
  - Each gives one `op_err` pulse and no `tx_start`.
  - The next valid triple (0x0F, 0xF0, 0x25) transmits 0xFF.
- **Drop while busy:** rx strobes 0xAA and 0xBB during WAIT_TX are ignored. After `tx_done`, rx 0x01, 0x01, 0x20 → 0x02.
- **Reset mid-operation:** reset asserted one cycle while in WAIT_OP, and again while in WAIT_TX.
  - All outputs are 0 the next cycle; no `tx_start`.
  - A fresh triple works normally.
- **Timeout (macro on, TIMEOUT_CYCLES=16):** rx 0x05, then silence.
  - `timeout` pulses after 16 cycles and the state returns to WAIT_A.
  - An rx strobe exactly at cycle 16 is accepted instead, with no timeout.
